// File: rtl/memory_sink_if.sv
// Stream-in / RAM-write bus of the capture sink.
// The slave side is the sink: it takes the word stream and drives the RAM write port.
interface memory_sink_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wren
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_wdata,
    output mem_wren
  );
endinterface

// File: rtl/memory_sink.sv
// Capture end of the on-chip RAM replay path.
// Accepted stream words are written to an external single-port RAM from
// address 0 upward with a fixed one-cycle registered write latency.
// WRAP=0 stops at a full RAM; WRAP=1 overwrites circularly until stop.
module memory_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  memory_sink_if.slave      bus,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              done,
  output logic              overflow
);

  // DEPTH expressed in the wr_count width: a single 1 above the address bits.
  localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1'b1);
  localparam bit                WRAP_EN   = (WRAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W-1:0]   ptr_s;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W:0]     count_s;
  logic [ADDR_W:0]     count_inc_s;
  logic                full_r;
  logic                full_s;
  logic                overflow_r;
  logic                overflow_s;
  logic                accept_s;
  logic                wren_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;

  // Handshake: ready is a pure function of the state register.
  assign bus.in_ready = (state_r == ST_CAPTURE);
  assign accept_s     = bus.in_valid && (state_r == ST_CAPTURE);

  // Count saturates at DEPTH so a wrapping capture reports a full RAM.
  assign count_inc_s  = (count_r == DEPTH_C) ? count_r : (count_r + COUNT_ONE);

  // Next-state, pointer, count and overflow decisions.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    count_s    = count_r;
    overflow_s = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_CAPTURE;
          ptr_s      = {ADDR_W{1'b0}};
          count_s    = {(ADDR_W + 1){1'b0}};
          overflow_s = 1'b0;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (start) begin
          // Re-arm: a word accepted at this edge is still written, but the
          // fresh capture starts counting from address 0.
          state_s    = ST_CAPTURE;
          ptr_s      = {ADDR_W{1'b0}};
          count_s    = {(ADDR_W + 1){1'b0}};
          overflow_s = 1'b0;
        end else begin
          if (accept_s) begin
            ptr_s   = ptr_r + PTR_ONE;
            count_s = count_inc_s;
          end else begin
            ptr_s   = ptr_r;
            count_s = count_r;
          end
          // Filling a non-wrapping RAM ends capture at the same edge as the
          // last accept; its write still issues on the following cycle.
          if ((!WRAP_EN && accept_s && (count_inc_s == DEPTH_C)) || stop) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s    = ST_CAPTURE;
          ptr_s      = {ADDR_W{1'b0}};
          count_s    = {(ADDR_W + 1){1'b0}};
          overflow_s = 1'b0;
        end else begin
          state_s = ST_DONE;
          // A word offered to a full, non-wrapping sink is lost: flag it.
          if (!WRAP_EN && full_r && bus.in_valid) begin
            overflow_s = 1'b1;
          end else begin
            overflow_s = overflow_r;
          end
        end
      end
      default: begin
        state_s    = ST_IDLE;
        ptr_s      = {ADDR_W{1'b0}};
        count_s    = {(ADDR_W + 1){1'b0}};
        overflow_s = 1'b0;
      end
    endcase
    full_s = (count_s == DEPTH_C);
  end

  // State, pointer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W + 1){1'b0}};
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      count_r    <= count_s;
      full_r     <= full_s;
      overflow_r <= overflow_s;
    end
  end

  // RAM write port: one cycle after each accept, address = pointer at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      wren_r <= accept_s;
      if (accept_s) begin
        addr_r  <= ptr_r;
        wdata_r <= bus.in_data;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign bus.mem_wren  = wren_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign wr_count      = count_r;
  assign full          = full_r;
  assign done          = (state_r == ST_DONE);
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_memory_sink.sv
// Bench for memory_sink: two instances (WRAP=0 and WRAP=1, 8-word RAM) see
// the same stimulus; a behavioural model per instance predicts every output.
module tb_memory_sink;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, in_valid;
  logic [DW-1:0] in_data;

  memory_sink_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  memory_sink_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  logic [AW:0]   o_cnt   [2];
  logic          o_full  [2];
  logic          o_done  [2];
  logic          o_ovf   [2];
  logic          o_rdy   [2];
  logic          o_wren  [2];
  logic [AW-1:0] o_addr  [2];
  logic [DW-1:0] o_wdata [2];

  assign o_rdy[0]   = bus0.in_ready;
  assign o_rdy[1]   = bus1.in_ready;
  assign o_wren[0]  = bus0.mem_wren;
  assign o_wren[1]  = bus1.mem_wren;
  assign o_addr[0]  = bus0.mem_addr;
  assign o_addr[1]  = bus1.mem_addr;
  assign o_wdata[0] = bus0.mem_wdata;
  assign o_wdata[1] = bus1.mem_wdata;

  memory_sink #(.DATA_W(DW), .ADDR_W(AW), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus0.slave),
    .wr_count(o_cnt[0]), .full(o_full[0]), .done(o_done[0]), .overflow(o_ovf[0])
  );

  memory_sink #(.DATA_W(DW), .ADDR_W(AW), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus1.slave),
    .wr_count(o_cnt[1]), .full(o_full[1]), .done(o_done[1]), .overflow(o_ovf[1])
  );

  // Behavioural RAM fed by each DUT's write port.
  logic [DW-1:0] b_ram [2][DEPTH];
  always @(posedge clk) begin
    if (bus0.mem_wren) b_ram[0][bus0.mem_addr] <= bus0.mem_wdata;
    if (bus1.mem_wren) b_ram[1][bus1.mem_addr] <= bus1.mem_wdata;
  end

  // Reference model state.
  bit            m_cap  [2];
  bit            m_done [2];
  bit            m_ovf  [2];
  bit            m_wv   [2];
  int            m_ptr  [2];
  int            m_cnt  [2];
  logic [DW-1:0] m_wa   [2];
  logic [DW-1:0] m_wd   [2];
  logic [DW-1:0] m_ram  [2][DEPTH];
  bit            m_wrt  [2][DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge for instance k (k==1 wraps).
  task automatic model_edge(input int k);
    bit wrap;
    bit acc;
    wrap = (k == 1);
    acc  = m_cap[k] && in_valid;
    if (m_wv[k]) begin
      m_ram[k][m_wa[k]] = m_wd[k];
      m_wrt[k][m_wa[k]] = 1'b1;
    end
    if (rst) begin
      m_cap[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0; m_wv[k] = 1'b0;
      m_ptr[k] = 0; m_cnt[k] = 0; m_wa[k] = '0; m_wd[k] = '0;
    end else begin
      m_wv[k] = acc;
      if (acc) begin
        m_wa[k] = m_ptr[k];
        m_wd[k] = in_data;
      end
      if (m_done[k] && (m_cnt[k] == DEPTH) && !wrap && in_valid) m_ovf[k] = 1'b1;
      if (start) begin
        m_cap[k] = 1'b1; m_done[k] = 1'b0;
        m_ptr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
      end else if (m_cap[k]) begin
        if (acc) begin
          m_ptr[k] = (m_ptr[k] + 1) % DEPTH;
          if (m_cnt[k] < DEPTH) m_cnt[k]++;
        end
        if ((!wrap && m_cnt[k] == DEPTH) || stop) begin
          m_cap[k] = 1'b0; m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k),  o_rdy[k],   m_cap[k]);
      chk($sformatf("mem_wren[%0d]", k),  o_wren[k],  m_wv[k]);
      chk($sformatf("mem_addr[%0d]", k),  o_addr[k],  m_wa[k]);
      chk($sformatf("mem_wdata[%0d]", k), o_wdata[k], m_wd[k]);
      chk($sformatf("wr_count[%0d]", k),  o_cnt[k],   m_cnt[k]);
      chk($sformatf("full[%0d]", k),      o_full[k],  (m_cnt[k] == DEPTH));
      chk($sformatf("done[%0d]", k),      o_done[k],  m_done[k]);
      chk($sformatf("overflow[%0d]", k),  o_ovf[k],   m_ovf[k]);
    end
  endtask

  // One cycle: drive at the falling edge, model the rising edge, check after it.
  task automatic step(input bit r, input bit s, input bit p, input bit v, input logic [DW-1:0] d);
    rst = r; start = s; stop = p; in_valid = v; in_data = d;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [DW-1:0] gap_data;
    bit            gap_valid;
    bit [5:0]      gap_pat;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_count", o_cnt[0], 4'd0);
    chk("reset_ready", o_rdy[0], 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD);   // stop in IDLE ignored
    chk("idle_stop_done", o_done[0], 1'b0);

    // Basic capture of 0xA0..0xA4.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("basic_count", o_cnt[0], 4'd5);
    chk("basic_done",  o_done[0], 1'b1);
    chk("basic_full",  o_full[0], 1'b0);
    for (int i = 0; i < 5; i++) chk($sformatf("basic_ram%0d", i), b_ram[0][i], 32'hA0 + 32'(i));

    // Back-pressure with gaps: valid 1,0,1,1,0,1, data 1..6.
    gap_pat = 6'b101101;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      gap_valid = gap_pat[5 - i];
      gap_data  = 32'(i + 1);
      step(1'b0, 1'b0, 1'b0, gap_valid, gap_data);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("gap_count", o_cnt[0], 4'd4);
    chk("gap_ram0", b_ram[0][0], 32'h1);
    chk("gap_ram1", b_ram[0][1], 32'h3);
    chk("gap_ram2", b_ram[0][2], 32'h4);
    chk("gap_ram3", b_ram[0][3], 32'h6);

    // Fill: 10 words into the 8-word RAM.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i));
      if (i == 7) begin
        chk("fill_ready_low", o_rdy[0], 1'b0);
        chk("fill_full",      o_full[0], 1'b1);
        chk("fill_done",      o_done[0], 1'b1);
      end
      if (i == 8) chk("fill_overflow", o_ovf[0], 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("fill_ram%0d", i), b_ram[0][i], 32'h100 + 32'(i));
    chk("fill_overflow_hold", o_ovf[0], 1'b1);
    chk("fill_wrap_no_ovf",   o_ovf[1], 1'b0);

    // Wrap: 11 words 0x10..0x1A, then stop.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("start_clears_ovf", o_ovf[0], 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10 + 32'(i));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("wrap_ram%0d", i), b_ram[1][i], 32'h18 + 32'(i));
    for (int i = 3; i < 8; i++) chk($sformatf("wrap_ram%0d", i), b_ram[1][i], 32'h10 + 32'(i));
    chk("wrap_count", o_cnt[1], 4'd8);
    chk("wrap_full",  o_full[1], 1'b1);
    chk("wrap_ovf",   o_ovf[1], 1'b0);
    chk("wrap_ptr",   dut1.ptr_r, 3'd3);

    // stop together with an accept of 0x55.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
    chk("stopacc_wren",  o_wren[0], 1'b1);
    chk("stopacc_wdata", o_wdata[0], 32'h55);
    chk("stopacc_done",  o_done[0], 1'b1);
    chk("stopacc_count", o_cnt[0], 4'd1);

    // start+stop together during CAPTURE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h61);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h62);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("ss_count", o_cnt[0], 4'd0);
    chk("ss_ptr",   dut0.ptr_r, 3'd0);
    chk("ss_ready", o_rdy[0], 1'b1);
    chk("ss_done",  o_done[0], 1'b0);

    // Reset mid-capture with in_valid held high.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h70 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
    chk("rstmid_wren",  o_wren[0], 1'b0);
    chk("rstmid_count", o_cnt[0], 4'd0);
    chk("rstmid_ready", o_rdy[0], 1'b0);
    chk("rstmid_done",  o_done[0], 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h88);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    chk("rstmid_addr",  o_addr[0], 3'd0);
    chk("rstmid_wdata", o_wdata[0], 32'h99);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), $urandom);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++)
        if (m_wrt[k][a]) chk($sformatf("rand_ram%0d_%0d", k, a), b_ram[k][a], m_ram[k][a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
